// File: rtl/data_sram_slave_if.sv
// ---------------------------------------------------------------------------
// data_sram_slave_if
// Groups the CPU data-side SRAM-like bus into one bundle.
//
// Signals
//   data_req     request valid from the CPU memory stage
//   data_wr      1 = write, 0 = read
//   data_size    access size (0 byte, 1 half, 2 word); informational only
//   data_addr    byte address
//   data_wstrb   byte-lane write enables, lane i = bits [8i+7:8i]
//   data_wdata   lane-aligned write data
//   data_addr_ok request accepted this cycle
//   data_rdata   aligned read word on a read response, 0 otherwise
//   data_data_ok one-cycle response pulse, one per accepted request
//
// Modports
//   master  the requester (CPU side)
//   slave   the memory (data_sram_slave)
// ---------------------------------------------------------------------------
interface data_sram_slave_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic [31:0] data_rdata;
   logic        data_data_ok;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      input  data_addr_ok, data_rdata, data_data_ok
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      output data_addr_ok, data_rdata, data_data_ok
   );
endinterface

// File: rtl/data_sram_slave.sv
// ---------------------------------------------------------------------------
// data_sram_slave
// Word-organised RAM behind a pipelined request/response bus. Requests are
// accepted while fewer than MAX_OUT transactions are outstanding; each one
// is answered with a single data_ok pulse LATENCY cycles after acceptance,
// strictly in acceptance order.
//
// Parameters
//   ADDR_W   log2 of the RAM word count
//   LATENCY  cycles from address handshake to data_ok (1..7)
//   MAX_OUT  maximum accepted-but-unanswered transactions (1..4)
//
// Ports
//   clk      clock, all state updates on the rising edge
//   reset    synchronous, active-high reset (RAM contents are not reset)
//   bus      data_sram_slave_if.slave bundle
// ---------------------------------------------------------------------------
module data_sram_slave #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2,
   parameter int MAX_OUT = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   data_sram_slave_if.slave      bus
);

   localparam int               WORDS     = 1 << ADDR_W;
   localparam int               PTR_W     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [2:0]       MAX_CNT   = 3'(MAX_OUT);
   localparam logic [2:0]       LOAD_CNT  = 3'(LATENCY - 1);
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_OUT - 1);

   logic [31:0]       mem [0:WORDS-1];
   logic [ADDR_W-1:0] word_idx;

   logic [MAX_OUT-1:0] q_valid;
   logic               q_wr   [MAX_OUT];
   logic [31:0]        q_word [MAX_OUT];
   logic [2:0]         q_cnt  [MAX_OUT];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [2:0]         count;

   logic handshake;
   logic pop;
   logic unused_bits;

   // Size is informational and only the word-index bits of the address
   // select a RAM word; everything else is deliberately ignored.
   assign unused_bits = ^{bus.data_size, bus.data_addr};

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_SLOT) ? '0 : p + 1'b1;
   endfunction

   // Upper address bits are dropped, so addresses wrap modulo the RAM size.
   assign word_idx = bus.data_addr[ADDR_W+1:2];

   // Acceptance looks only at the registered count, never at a same-cycle
   // pop, which keeps addr_ok off the response path.
   assign handshake = !reset && bus.data_req && (count < MAX_CNT);

   // The head entry answers once its countdown has reached zero.
   assign pop = !reset && q_valid[head] && (q_cnt[head] == 3'd0);

   assign bus.data_addr_ok = handshake;
   assign bus.data_data_ok = pop;
   assign bus.data_rdata   = (pop && !q_wr[head]) ? q_word[head] : 32'h0;

   // Byte-lane RAM write. The RAM has no reset so that a mid-operation reset
   // leaves its contents intact; a write with all strobes low changes nothing
   // but is still queued for a response below.
   always_ff @(posedge clk) begin
      if (handshake && bus.data_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.data_wstrb[i]) begin
               mem[word_idx][8*i +: 8] <= bus.data_wdata[8*i +: 8];
            end
         end
      end
   end

   // Transaction FIFO. Every valid entry counts down toward zero; the head
   // is popped when it reaches zero, and a new entry is appended at the tail
   // with the full word captured at acceptance (reads see all earlier
   // writes because the RAM update lands at the same edge as the capture).
   // Only one handshake per cycle exists, so no write can race the capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_valid <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
      end else begin
         for (int i = 0; i < MAX_OUT; i++) begin
            if (q_valid[i] && (q_cnt[i] != 3'd0)) begin
               q_cnt[i] <= q_cnt[i] - 3'd1;
            end
         end

         if (pop) begin
            q_valid[head] <= 1'b0;
            head          <= next_ptr(head);
         end

         if (handshake) begin
            q_valid[tail] <= 1'b1;
            q_wr[tail]    <= bus.data_wr;
            q_word[tail]  <= bus.data_wr ? 32'h0 : mem[word_idx];
            q_cnt[tail]   <= LOAD_CNT;
            tail          <= next_ptr(tail);
         end

         case ({handshake, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_data_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_data_sram_slave
// Scoreboard bench for data_sram_slave. The driver issues requests, checks
// addr_ok against the number of unanswered transactions, and on every
// accepted request pushes the expected response (from a byte-addressed
// memory model) into a queue. A separate monitor pops that queue whenever
// data_ok appears and checks rdata and arrival cycle.
// ---------------------------------------------------------------------------
module tb_data_sram_slave;

   localparam int ADDR_W  = 10;
   localparam int LATENCY = 2;
   localparam int MAX_OUT = 2;
   localparam int BYTES   = 4 * (1 << ADDR_W);

   logic clk;
   logic reset;

   data_sram_slave_if bus ();

   data_sram_slave #(
      .ADDR_W (ADDR_W),
      .LATENCY(LATENCY),
      .MAX_OUT(MAX_OUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] data;
      int          cyc;
      logic        isRead;
   } expect_t;

   expect_t     sbQ[$];
   logic [7:0]  modelMem [0:BYTES-1];
   int          checkCount   = 0;
   int          passCount    = 0;
   int          cyc          = 0;
   int          respCount    = 0;
   int          acceptCount  = 0;
   int          droppedCount = 0;
   logic [31:0] lastRead     = '0;
   logic [31:0] prevRead     = '0;
   logic        rstVal       = 1'b1;

   // Free-running clock with a cycle counter used to time responses.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Byte address of the first byte of the word an address selects.
   function automatic int modelBase(input logic [31:0] addr);
      logic [31:0] w;
      w = (addr >> 2) % 32'(1 << ADDR_W);
      return int'(w) * 4;
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] addr);
      int b;
      b = modelBase(addr);
      return {modelMem[b+3], modelMem[b+2], modelMem[b+1], modelMem[b]};
   endfunction

   task automatic modelWrite(input logic [31:0] addr, input logic [3:0] wstrb,
                             input logic [31:0] wdata);
      int b;
      b = modelBase(addr);
      for (int i = 0; i < 4; i++) begin
         if (wstrb[i]) modelMem[b+i] = wdata[8*i +: 8];
      end
   endtask

   // One bus cycle: drive at +1 after the edge, sample at +4, record any
   // handshake in the model and scoreboard.
   task automatic applyStimulus(input logic req, input logic wr,
                                input logic [31:0] addr, input logic [3:0] wstrb,
                                input logic [31:0] wdata, output logic accepted);
      expect_t e;
      logic    expOk;
      @(posedge clk);
      #1;
      reset          = rstVal;
      bus.data_req   = req;
      bus.data_wr    = wr;
      bus.data_size  = 2'd2;
      bus.data_addr  = addr;
      bus.data_wstrb = wstrb;
      bus.data_wdata = wdata;
      if (rstVal) begin
         droppedCount += sbQ.size();
         sbQ.delete();
      end
      #3;
      expOk = !rstVal && req && (sbQ.size() < MAX_OUT);
      checkOutput("addr_ok", 32'(bus.data_addr_ok), 32'(expOk));
      accepted = !rstVal && req && bus.data_addr_ok;
      if (accepted) begin
         acceptCount++;
         e.cyc    = cyc + LATENCY;
         e.isRead = !wr;
         if (wr) begin
            e.data = 32'h0;
            modelWrite(addr, wstrb, wdata);
         end else begin
            e.data = modelRead(addr);
         end
         sbQ.push_back(e);
         checkOutput("outstanding_le_max", 32'(sbQ.size() <= MAX_OUT), 32'd1);
      end
   endtask

   task automatic sendAccepted(input logic wr, input logic [31:0] addr,
                               input logic [3:0] wstrb, input logic [31:0] wdata);
      logic acc;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         applyStimulus(1'b1, wr, addr, wstrb, wdata, acc);
         tries++;
      end
      checkOutput("accept_within_bound", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc);
   endtask

   task automatic drain(input string name);
      logic acc;
      int   n;
      n = 0;
      while (sbQ.size() != 0 && n < 50) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc);
         n++;
      end
      idle(1);
      checkOutput({name, "_drained"}, 32'(sbQ.size()), 32'd0);
   endtask

   // Response monitor: runs on the falling edge, away from the driver's
   // sample point, and consumes one scoreboard entry per data_ok.
   always @(negedge clk) begin : monitor
      expect_t e;
      if (reset) begin
         checkOutput("reset_data_ok", 32'(bus.data_data_ok), 32'd0);
         checkOutput("reset_rdata", bus.data_rdata, 32'h0);
      end else if (bus.data_data_ok) begin
         if (sbQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_data_ok: data_ok=1 at cycle %0d, required no response", cyc);
         end else begin
            e = sbQ.pop_front();
            respCount++;
            checkOutput("rdata", bus.data_rdata, e.data);
            checkOutput("response_cycle", 32'(cyc), 32'(e.cyc));
            if (e.isRead) begin
               prevRead = lastRead;
               lastRead = bus.data_rdata;
            end
         end
      end else begin
         checkOutput("idle_rdata", bus.data_rdata, 32'h0);
      end
   end

   initial begin : stimulus
      logic acc;
      int   respBefore;
      logic [31:0] addr;

      reset          = 1'b1;
      bus.data_req   = 1'b0;
      bus.data_wr    = 1'b0;
      bus.data_size  = 2'd0;
      bus.data_addr  = 32'h0;
      bus.data_wstrb = 4'h0;
      bus.data_wdata = 32'h0;

      // Requests during reset must not be accepted.
      rstVal = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, acc);
      rstVal = 1'b0;

      // Give the low 16 words known contents.
      for (int i = 0; i < 16; i++) sendAccepted(1'b1, 32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i));
      drain("prefill");

      // Full write then read back.
      sendAccepted(1'b1, 32'h100, 4'hF, 32'h11223344);
      sendAccepted(1'b0, 32'h100, 4'h0, 32'h0);
      drain("full_write");
      checkOutput("full_write_readback", lastRead, 32'h11223344);

      // Single-lane write merges into the existing word.
      sendAccepted(1'b1, 32'h100, 4'b0010, 32'hAABBCCDD);
      sendAccepted(1'b0, 32'h100, 4'h0, 32'h0);
      drain("lane_write");
      checkOutput("lane_write_readback", lastRead, 32'h1122CC44);

      // Address wraparound.
      sendAccepted(1'b0, 32'h4, 4'h0, 32'h0);
      sendAccepted(1'b0, 32'h4004, 4'h0, 32'h0);
      drain("wrap");
      checkOutput("wrap_low", prevRead, 32'hC0DE0001);
      checkOutput("wrap_high", lastRead, 32'hC0DE0001);

      // Back-to-back reads: acceptance settles into accept, accept, stall.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 1'b0, 32'(4 * (i % 16)), 4'h0, 32'h0, acc);
         checkOutput("addr_ok_pattern", 32'(acc), 32'((i % 3) != 2));
      end
      drain("streaming");

      // Reset with two reads in flight discards both responses.
      respBefore = respCount;
      sendAccepted(1'b0, 32'h8, 4'h0, 32'h0);
      sendAccepted(1'b0, 32'hC, 4'h0, 32'h0);
      rstVal = 1'b1;
      idle(2);
      rstVal = 1'b0;
      idle(4);
      checkOutput("no_response_after_reset", 32'(respCount - respBefore), 32'd0);
      sendAccepted(1'b0, 32'h8, 4'h0, 32'h0);
      drain("post_reset");
      checkOutput("post_reset_one_response", 32'(respCount - respBefore), 32'd1);
      checkOutput("post_reset_read", lastRead, 32'hC0DE0002);
      sendAccepted(1'b0, 32'h100, 4'h0, 32'h0);
      drain("ram_kept");
      checkOutput("ram_kept_over_reset", lastRead, 32'h1122CC44);

      // Random traffic confined to the initialised words, with random upper
      // address bits to exercise wraparound.
      for (int i = 0; i < 600; i++) begin
         addr = $urandom & ~32'h0000_0FC0;
         applyStimulus($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), addr,
                       4'($urandom), $urandom, acc);
      end
      drain("random");
      checkOutput("responses_match_accepts", 32'(respCount), 32'(acceptCount - droppedCount));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/data_sram_slave.md
DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 10, meaning log2 of the word count of the backing RAM.
REQ-002 The block SHALL take parameter LATENCY, default 2, meaning cycles from address handshake to data_ok (legal range 1..7).
REQ-003 The block SHALL take parameter MAX_OUT, default 2, meaning the maximum number of accepted transactions still awaiting data_ok (legal range 1..4).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_req  input  1  request valid from the CPU memory stage.
REQ-007 data_wr  input  1  1 = write, 0 = read.
REQ-008 data_size  input  2  access size (0 = byte, 1 = half, 2 = word); informational only.
REQ-009 data_addr  input  32  byte address.
REQ-010 data_wstrb  input  4  byte-lane write enables, lane i = bits [8i+7:8i].
REQ-011 data_wdata  input  32  write data, already lane-aligned.
REQ-012 data_addr_ok  output  1  request accepted this cycle.
REQ-013 data_rdata  output  32  full aligned word for a read response; 0 for a write response.
REQ-014 data_data_ok  output  1  one-cycle response pulse, one per accepted request.

Function
REQ-015 The block SHALL assert data_addr_ok combinationally when data_req=1 and outstanding count < MAX_OUT; a handshake occurs when data_req && data_addr_ok.
REQ-016 The block SHALL ignore the address and data inputs in any cycle without a handshake.
REQ-017 The block SHALL index the RAM with data_addr[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo 4*2^ADDR_W bytes.
REQ-018 On a write handshake, the block SHALL update each RAM byte lane whose data_wstrb bit is 1 at the same clock edge; lanes with strobe 0 stay unchanged; wstrb=0 performs no write but still produces data_ok.
REQ-019 On a read handshake, the block SHALL sample the full RAM word at that edge, reflecting every write handshaked in earlier cycles, and hold it in the transaction queue; byte/half extraction is the requester's job.
REQ-020 The block SHALL keep accepted transactions in a FIFO queue of depth MAX_OUT; each entry holds wr flag, captured word and a down-counter loaded with LATENCY-1 at acceptance.
REQ-021 Each cycle, every valid entry's counter SHALL decrement saturating at 0.
REQ-022 The block SHALL drive data_data_ok=1 for exactly one cycle when the head entry is valid with counter 0, with data_rdata = captured word (read) or 0 (write), and pop that entry at that edge.
REQ-023 Responses SHALL return strictly in acceptance order; with equal per-entry latency, a handshake at cycle T SHALL yield data_ok at cycle T+LATENCY.
REQ-024 Outstanding count SHALL increment on handshake, decrement on pop, and stay unchanged when both occur in the same cycle.
REQ-025 data_addr_ok SHALL NOT depend on a same-cycle pop: when count = MAX_OUT, addr_ok stays 0 for that cycle even if data_ok is issued.
REQ-026 The block SHALL never drop, merge or cancel an accepted transaction; requester-side pipeline flushes do not affect it.
REQ-027 data_rdata SHALL be 0 in every cycle where data_data_ok=0.

Reset
REQ-028 While reset=1, the block SHALL drive data_addr_ok=0, data_data_ok=0 and data_rdata=0, and clear all queue valid bits and the outstanding count.
REQ-029 Reset asserted mid-operation SHALL discard all pending responses (no data_ok emitted after reset) and SHALL leave RAM contents unchanged.
REQ-030 RAM contents SHALL have no reset value; a read of a never-written word returns whatever the RAM holds.

Verification
REQ-031 Write 0x11223344 to 0x100 with wstrb=4'hF at cycle T, then read 0x100 -> write data_ok at T+2 with rdata 0; read data_ok with rdata 0x11223344.
REQ-032 Write 0xAABBCCDD with wstrb=4'b0010 to 0x100 after REQ-031 -> subsequent read returns 0x1122CC44.
REQ-033 Hold data_req=1 with reads, MAX_OUT=2, LATENCY=2 -> addr_ok pattern 1,1,0,1,1,0..., exactly one data_ok per accept, in order.
REQ-034 Read 0x4 then 0x4004 with ADDR_W=10 -> both return the same word (wraparound).
REQ-035 Accept two reads, assert reset one cycle later -> no data_ok during or after reset; next read handshake yields data_ok after exactly LATENCY cycles.
REQ-036 Random req/wr/wstrb stream checked against a byte-level reference model -> every rdata matches, response count equals accept count, outstanding never exceeds MAX_OUT.
